// File: rtl/onewire_master_param.sv
// onewire_master_param: open-drain 1-Wire master issuing reset/presence and LSB-first word write/read slots.
module onewire_master_param #(
  parameter int DATA_W = 8,
  parameter int T_RSTL = 480,
  parameter int T_PDS  = 70,
  parameter int T_RSTH = 410,
  parameter int T_SLOT = 65,
  parameter int T_W1L  = 6,
  parameter int T_W0L  = 60,
  parameter int T_MSR  = 15,
  parameter int T_REC  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_presence,
  output logic              rsp_err,
  output logic              en,
  inout  wire               port
);
  localparam int M1 = T_RSTL > T_RSTH ? T_RSTL : T_RSTH;
  localparam int M2 = T_SLOT > T_REC ? T_SLOT : T_REC;
  localparam int CW = $clog2(M1 > M2 ? M1 : M2) + 1;
  localparam int IW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  typedef enum logic [2:0] {IDLE, RST_LOW, RST_HIGH, SLOT_LOW, SLOT_HIGH, REC, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, low_end;
  logic [IW-1:0] idx, idx_n;
  logic [DATA_W-1:0] dat, sh;
  logic [1:0] op, op_n, sync;
  logic pres, fin, smp;
  assign port = en ? 1'b0 : 1'bz;
  assign en = state == RST_LOW || state == SLOT_LOW;
  assign cmd_ready = state == IDLE;
  assign rsp_valid = state == DONE;
  assign op_n = state == IDLE ? cmd_op : op;
  assign low_end = dat[idx] ? CW'(T_W1L - 1) : CW'(T_W0L - 1);
  // write-0 slots are still low at the sample point, so the readback is 0 by construction
  assign smp = (state == SLOT_LOW || state == SLOT_HIGH) && cnt == CW'(T_MSR);
  assign fin = state_n == DONE && state != DONE;
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    idx_n = idx;
    case (state)
      IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        if (cmd_valid) state_n = cmd_op == 2'b00 ? RST_LOW : cmd_op == 2'b11 ? DONE : SLOT_LOW;
      end
      RST_LOW: if (cnt == CW'(T_RSTL - 1)) begin
        state_n = RST_HIGH;
        cnt_n = '0;
      end
      RST_HIGH: state_n = cnt == CW'(T_RSTH - 1) ? DONE : RST_HIGH;
      SLOT_LOW: state_n = cnt == low_end ? SLOT_HIGH : SLOT_LOW;
      SLOT_HIGH: if (cnt == CW'(T_SLOT - 1)) begin
        state_n = REC;
        cnt_n = '0;
      end
      REC: if (cnt == CW'(T_REC - 1)) begin
        cnt_n = '0;
        state_n = idx == IW'(DATA_W - 1) ? DONE : SLOT_LOW;
        idx_n = idx == IW'(DATA_W - 1) ? idx : idx + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      dat <= '0;
      sh <= '0;
      op <= '0;
      sync <= 2'b11;
      pres <= 1'b0;
      rsp_data <= '0;
      rsp_presence <= 1'b0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sync <= {sync[0], port};
      if (cmd_ready && cmd_valid) begin
        op <= cmd_op;
        dat <= cmd_op == 2'b10 ? '1 : cmd_data;
      end
      if (smp) sh <= DATA_W'({sync[1], sh} >> 1);
      if (state == RST_HIGH && cnt == CW'(T_PDS)) pres <= ~sync[1];
      if (fin) begin
        rsp_err <= op_n == 2'b11;
        if (op_n == 2'b00) rsp_presence <= pres;
        if (op_n == 2'b01 || op_n == 2'b10) rsp_data <= sh;
      end
    end
  end
endmodule

// File: tb/tb_onewire_master_param.sv
// tb_onewire_master_param: directed + random 1-Wire transactions checked against a slot-level timing model.
module tb_onewire_master_param;
  localparam int W = 8;
  localparam int SLOT_P = 65 + 10;
  localparam int WORD = W * SLOT_P;
  localparam int RST_T = 480 + 410;
  logic clk = 0, reset = 0, cmd_valid = 0;
  logic [1:0] cmd_op = 0;
  logic [W-1:0] cmd_data = 0;
  wire cmd_ready, rsp_valid, rsp_presence, rsp_err, en;
  wire [W-1:0] rsp_data;
  wire line;
  logic slv_low = 0;
  int n_assert = 0, n_fail = 0;
  int mode = 0, cmd_id = 0, seen_id = 0;
  logic [W-1:0] mask = 0;
  int slot = -1, hold = 0, rel = -1, run = 0, ncyc = 0;
  logic en_d = 0;
  int pl[$], ps[$];

  pullup (line);
  assign line = slv_low ? 1'b0 : 1'bz;
  always #5 clk = ~clk;

  onewire_master_param #(.DATA_W(W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_presence(rsp_presence), .rsp_err(rsp_err), .en(en), .port(line)
  );

  // bus monitor and slave: records en pulse lengths/starts, pulls the line per the selected mode
  always @(negedge clk) begin
    if (cmd_id != seen_id) begin
      seen_id = cmd_id;
      pl.delete();
      ps.delete();
      run = 0;
      slot = -1;
      hold = 0;
    end
    ncyc++;
    if (en) begin
      if (!en_d) ps.push_back(ncyc);
      run++;
    end else if (en_d) begin
      pl.push_back(run);
      run = 0;
    end
    if (en && !en_d) begin
      slot++;
      if (mode == 2 && slot < W && mask[slot]) hold = 30;
    end
    if (!en && en_d) rel = 0;
    else if (rel >= 0) rel++;
    slv_low = hold > 0 || (mode == 1 && rel >= 20 && rel <= 140);
    if (hold > 0) hold--;
    en_d = en;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_cmd(input logic [1:0] op, input logic [W-1:0] d, input int md, input logic [W-1:0] mk);
    @(negedge clk);
    mode = md;
    mask = mk;
    cmd_id++;
    chk("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1;
    cmd_op = op;
    cmd_data = d;
    @(posedge clk);
    #1 cmd_valid = 0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 2000);
    chk("rsp_timeout", lat < 2000, 1);
  endtask

  // expected en pulse per bit: 6 cycles for a 1, 60 for a 0, one pulse every 75 cycles
  task automatic chk_pulses(input logic [W-1:0] d);
    chk("pulse_count", pl.size(), W);
    for (int i = 0; i < W && i < pl.size(); i++) begin
      chk($sformatf("pulse_len%0d", i), pl[i], d[i] ? 6 : 60);
      if (i > 0) chk($sformatf("pulse_pitch%0d", i), ps[i] - ps[i-1], SLOT_P);
    end
  endtask

  initial begin
    int lat;
    logic [W-1:0] d, mk, e;
    logic [1:0] op;
    repeat (3) @(negedge clk);
    chk("rst_en", en, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_pres", rsp_presence, 0);
    chk("rst_err", rsp_err, 0);
    reset = 1;
    @(negedge clk);
    chk("rst_ready", cmd_ready, 1);

    start_cmd(2'b01, 8'hA5, 0, 0);
    wait_rsp(lat);
    chk("a5_lat", lat >= WORD && lat <= WORD + 2, 1);
    chk("a5_data", rsp_data, 8'hA5);
    chk("a5_err", rsp_err, 0);
    chk_pulses(8'hA5);
    @(negedge clk);
    chk("valid_one_cycle", rsp_valid, 0);
    chk("ready_after_done", cmd_ready, 1);

    start_cmd(2'b00, 0, 0, 0);
    wait_rsp(lat);
    chk("noslave_lat", lat >= RST_T && lat <= RST_T + 2, 1);
    chk("noslave_pres", rsp_presence, 0);
    chk("noslave_err", rsp_err, 0);
    chk("reset_keeps_data", rsp_data, 8'hA5);
    chk("reset_pulse", pl.size() == 1 && pl[0] == 480, 1);

    start_cmd(2'b00, 0, 1, 0);
    wait_rsp(lat);
    chk("pres_lat", lat >= RST_T && lat <= RST_T + 2, 1);
    chk("pres_val", rsp_presence, 1);
    chk("pres_err", rsp_err, 0);

    start_cmd(2'b10, 0, 2, 8'b0000_1010);
    wait_rsp(lat);
    chk("read_lat", lat >= WORD && lat <= WORD + 2, 1);
    chk("read_data", rsp_data, 8'hF5);
    chk_pulses(8'hFF);

    for (int k = 0; k < 5; k++) begin
      d = W'($urandom);
      mk = W'($urandom);
      op = $urandom_range(1, 2);
      e = (op == 2'b10 ? {W{1'b1}} : d) & ~mk;
      start_cmd(op, d, 2, mk);
      wait_rsp(lat);
      chk($sformatf("rand%0d_lat", k), lat >= WORD && lat <= WORD + 2, 1);
      chk($sformatf("rand%0d_data", k), rsp_data, e);
      chk_pulses(op == 2'b10 ? {W{1'b1}} : d);
    end
    chk("word_keeps_pres", rsp_presence, 1);

    start_cmd(2'b01, 8'h3C, 0, 0);
    repeat (100) @(negedge clk);
    chk("busy_ready", cmd_ready, 0);
    cmd_valid = 1;
    cmd_op = 2'b10;
    cmd_data = 8'hFF;
    @(posedge clk);
    #1 cmd_valid = 0;
    wait_rsp(lat);
    chk("busy_data", rsp_data, 8'h3C);
    chk_pulses(8'h3C);

    start_cmd(2'b11, 8'h00, 0, 0);
    wait_rsp(lat);
    chk("illegal_lat", lat <= 2, 1);
    chk("illegal_err", rsp_err, 1);
    chk("illegal_no_bus", pl.size() + run, 0);
    chk("illegal_keeps_data", rsp_data, 8'h3C);

    start_cmd(2'b01, 8'h00, 0, 0);
    repeat (20) @(negedge clk);
    chk("midslot_en", en, 1);
    reset = 0;
    #1 chk("async_en_off", en, 0);
    repeat (2) @(negedge clk);
    chk("rst2_valid", rsp_valid, 0);
    chk("rst2_data", rsp_data, 0);
    chk("rst2_pres", rsp_presence, 0);
    chk("rst2_err", rsp_err, 0);
    chk("rst2_line", line, 1);
    reset = 1;
    @(negedge clk);
    chk("rst2_ready", cmd_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
